// File: rtl/centered_selection_builder_pkg.sv
// Shared fixed-point helpers for the parity-polytope projection blocks:
// ceil-log2, ONE/HALF construction and saturating arithmetic.
package centered_selection_builder_pkg;

  // Ceil-log2 with clog2Int(1) == 0, usable in constant expressions.
  function automatic int clog2Int(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

  function automatic int fixedOne(input int fractionWidth);
    return 1 << fractionWidth;
  endfunction

  function automatic int fixedHalf(input int fractionWidth);
    return 1 << (fractionWidth - 1);
  endfunction

  // Clamp to the signed range of a width-bit two's-complement value.
  function automatic int satClamp(input int value, input int width);
    int lo;
    int hi;
    lo = -(1 << (width - 1));
    hi = (1 << (width - 1)) - 1;
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

  function automatic int satAddSub(input int a, input int b, input logic subtract,
                                   input int width);
    return satClamp(subtract ? (a - b) : (a + b), width);
  endfunction

endpackage

// File: rtl/centered_selection_builder_argmin_tree.sv
// Pipelined argmin over packed unsigned keys, one tree level per register.
// Ties go to the lower index; padding leaves carry an all-ones key.
module argmin_tree
  import centered_selection_builder_pkg::*;
#(
  parameter int BLOCKLENGTH = 1,
  parameter int KEY_WIDTH = 9,
  localparam int LEVELS = clog2Int(BLOCKLENGTH),
  localparam int IDX_WIDTH = (LEVELS == 0) ? 1 : LEVELS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [KEY_WIDTH*BLOCKLENGTH-1:0] keys,
  output logic [IDX_WIDTH-1:0]             min_index
);

  if (LEVELS == 0) begin : gSingle
    logic unusedInputs;
    assign unusedInputs = ^{clk, reset, enable, keys};
    assign min_index = '0;
  end else begin : gTree
    localparam int LEAVES = 1 << LEVELS;
    localparam int INTERNAL = LEAVES - 1;
    localparam int NODES = 2 * LEAVES - 1;

    logic [KEY_WIDTH-1:0] leafKey [LEAVES];
    logic [IDX_WIDTH-1:0] leafIdx [LEAVES];
    logic [KEY_WIDTH-1:0] nodeKey_q [INTERNAL];
    logic [IDX_WIDTH-1:0] nodeIdx_q [INTERNAL];
    logic [KEY_WIDTH-1:0] allKey [NODES];
    logic [IDX_WIDTH-1:0] allIdx [NODES];
    logic unusedRootKey;

    for (genvar i = 0; i < LEAVES; i++) begin : gLeaf
      if (i < BLOCKLENGTH) begin : gReal
        assign leafKey[i] = keys[i*KEY_WIDTH +: KEY_WIDTH];
      end else begin : gPad
        assign leafKey[i] = '1;
      end
      assign leafIdx[i] = IDX_WIDTH'(i);
    end

    // Heap layout: node n has children 2n+1 and 2n+2, leaves sit after the internal nodes.
    always_comb begin
      for (int n = 0; n < INTERNAL; n++) begin
        allKey[n] = nodeKey_q[n];
        allIdx[n] = nodeIdx_q[n];
      end
      for (int i = 0; i < LEAVES; i++) begin
        allKey[INTERNAL + i] = leafKey[i];
        allIdx[INTERNAL + i] = leafIdx[i];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int n = 0; n < INTERNAL; n++) begin
          nodeKey_q[n] <= '0;
          nodeIdx_q[n] <= '0;
        end
      end else if (enable) begin
        for (int n = 0; n < INTERNAL; n++) begin
          if (allKey[2*n + 2] < allKey[2*n + 1]) begin
            nodeKey_q[n] <= allKey[2*n + 2];
            nodeIdx_q[n] <= allIdx[2*n + 2];
          end else begin
            nodeKey_q[n] <= allKey[2*n + 1];
            nodeIdx_q[n] <= allIdx[2*n + 1];
          end
        end
      end
    end

    assign unusedRootKey = ^nodeKey_q[0];
    assign min_index = nodeIdx_q[0];
  end

endmodule

// File: rtl/centered_selection_builder.sv
// Builds the odd-weight selection f for a check-node vector v and emits the
// flipped-and-centered vector c for the downstream selection test.
module centered_selection_builder
  import centered_selection_builder_pkg::*;
#(
  parameter int TAG_WIDTH = 32,
  parameter int BLOCKLENGTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int FRACTION_WIDTH = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ready_in,
  input  logic                              valid_in,
  input  logic [TAG_WIDTH-1:0]              tag_in,
  input  logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_in,
  output logic                              busy,
  output logic                              ready_out,
  output logic                              valid_out,
  output logic [TAG_WIDTH-1:0]              tag_out,
  output logic [BLOCKLENGTH-1:0]            selection_out,
  output logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_out
);

  localparam int LEVELS = clog2Int(BLOCKLENGTH);
  localparam int NUM_REGISTERS = 3 + LEVELS;
  localparam int KEY_WIDTH = DATA_WIDTH + 1;
  localparam int IDX_WIDTH = (LEVELS == 0) ? 1 : LEVELS;
  localparam int VEC_WIDTH = DATA_WIDTH * BLOCKLENGTH;
  localparam int CARRY_WIDTH = VEC_WIDTH + BLOCKLENGTH + 1;
  localparam int ONE = fixedOne(FRACTION_WIDTH);
  localparam int HALF = fixedHalf(FRACTION_WIDTH);

  logic [NUM_REGISTERS-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]          tag_q [NUM_REGISTERS];
  logic                          enable;

  logic [VEC_WIDTH-1:0]          vec0_q;
  logic [VEC_WIDTH-1:0]          vec1_q;
  logic [BLOCKLENGTH-1:0]        sel1_q, sel1_d;
  logic [KEY_WIDTH*BLOCKLENGTH-1:0] dist1_q, dist1_d;
  logic                          par1_q;

  logic [VEC_WIDTH-1:0]          vecF;
  logic [BLOCKLENGTH-1:0]        selF;
  logic                          parF;
  logic [IDX_WIDTH-1:0]          minIndex;

  logic [BLOCKLENGTH-1:0]        selOut_q, selection_d;
  logic [VEC_WIDTH-1:0]          dataOut_q, data_d;

  assign enable    = ready_in | ~valid_q[NUM_REGISTERS-1];
  assign ready_out = enable;
  assign valid_out = valid_q[NUM_REGISTERS-1];
  assign tag_out   = tag_q[NUM_REGISTERS-1];
  assign busy      = |valid_q;
  assign selection_out = selOut_q;
  assign data_out  = dataOut_q;

  // Valid/tag train: every stage advances together whenever the output is free or taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < NUM_REGISTERS; k++) tag_q[k] <= '0;
    end else if (enable) begin
      valid_q <= {valid_q[NUM_REGISTERS-2:0], valid_in};
      tag_q[0] <= tag_in;
      for (int k = 1; k < NUM_REGISTERS; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Distance to HALF is taken one bit wider than the data so it never wraps.
  always_comb begin
    int vi;
    int diff;
    sel1_d  = '0;
    dist1_d = '0;
    vi      = 0;
    diff    = 0;
    for (int i = 0; i < BLOCKLENGTH; i++) begin
      vi = int'($signed(vec0_q[i*DATA_WIDTH +: DATA_WIDTH]));
      sel1_d[i] = (vi >= HALF);
      diff = vi - HALF;
      if (diff < 0) diff = -diff;
      dist1_d[i*KEY_WIDTH +: KEY_WIDTH] = diff[KEY_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec0_q    <= '0;
      vec1_q    <= '0;
      sel1_q    <= '0;
      dist1_q   <= '0;
      par1_q    <= 1'b0;
      selOut_q  <= '0;
      dataOut_q <= '0;
    end else if (enable) begin
      vec0_q    <= data_in;
      vec1_q    <= vec0_q;
      sel1_q    <= sel1_d;
      dist1_q   <= dist1_d;
      par1_q    <= ^sel1_d;
      selOut_q  <= selection_d;
      dataOut_q <= data_d;
    end
  end

  argmin_tree #(
    .BLOCKLENGTH (BLOCKLENGTH),
    .KEY_WIDTH   (KEY_WIDTH)
  ) uArgmin (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .keys      (dist1_q),
    .min_index (minIndex)
  );

  // v, f0 and parity ride alongside the tree so they meet the winning index.
  if (LEVELS == 0) begin : gNoCarry
    assign {vecF, selF, parF} = {vec1_q, sel1_q, par1_q};
  end else begin : gCarry
    logic [CARRY_WIDTH-1:0] carry_q [LEVELS];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < LEVELS; k++) carry_q[k] <= '0;
      end else if (enable) begin
        carry_q[0] <= {vec1_q, sel1_q, par1_q};
        for (int k = 1; k < LEVELS; k++) carry_q[k] <= carry_q[k-1];
      end
    end
    assign {vecF, selF, parF} = carry_q[LEVELS-1];
  end

  always_comb begin
    int vi;
    int wi;
    int ci;
    selection_d = selF;
    data_d      = '0;
    vi          = 0;
    wi          = 0;
    ci          = 0;
    for (int i = 0; i < BLOCKLENGTH; i++) begin
      if (!parF && (int'(minIndex) == i)) selection_d[i] = ~selF[i];
    end
    for (int i = 0; i < BLOCKLENGTH; i++) begin
      vi = int'($signed(vecF[i*DATA_WIDTH +: DATA_WIDTH]));
      wi = selection_d[i] ? satAddSub(ONE, vi, 1'b1, DATA_WIDTH) : vi;
      ci = satAddSub(wi, HALF, 1'b1, DATA_WIDTH);
      data_d[i*DATA_WIDTH +: DATA_WIDTH] = ci[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_centered_selection_builder.sv
// Directed bench for centered_selection_builder with BLOCKLENGTH=4, 8-bit data,
// 6 fractional bits (ONE=64, HALF=32).
module tb_centered_selection_builder;

  localparam int TW = 32;
  localparam int BL = 4;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          ready_in;
  logic          valid_in;
  logic [TW-1:0] tag_in;
  logic [DW*BL-1:0] data_in;
  logic          busy;
  logic          ready_out;
  logic          valid_out;
  logic [TW-1:0] tag_out;
  logic [BL-1:0] selection_out;
  logic [DW*BL-1:0] data_out;

  int checks = 0;
  int errors = 0;

  centered_selection_builder #(
    .TAG_WIDTH      (TW),
    .BLOCKLENGTH    (BL),
    .DATA_WIDTH     (DW),
    .FRACTION_WIDTH (6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ready_in      (ready_in),
    .valid_in      (valid_in),
    .tag_in        (tag_in),
    .data_in       (data_in),
    .busy          (busy),
    .ready_out     (ready_out),
    .valid_out     (valid_out),
    .tag_out       (tag_out),
    .selection_out (selection_out),
    .data_out      (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Element 0 lands in the low byte.
  function automatic logic [31:0] packVec(input int e0, input int e1, input int e2, input int e3);
    logic [31:0] r;
    r[7:0]   = e0[7:0];
    r[15:8]  = e1[7:0];
    r[23:16] = e2[7:0];
    r[31:24] = e3[7:0];
    return r;
  endfunction

  task automatic runVector(input logic [31:0] vec, input logic [31:0] tag, output int cycles);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = vec;
    tag_in   = tag;
    @(negedge clk);
    valid_in = 1'b0;
    cycles   = 1;
    while (valid_out !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ready_in = 1'b0;
    valid_in = 1'b0;
    tag_in   = '0;
    data_in  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (tag_out !== '0) begin errors++; $display("[TB] FAIL reset_tag: got %h expected 0", tag_out); end
    checks++;
    if (selection_out !== '0) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 0", selection_out); end
    checks++;
    if (data_out !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", data_out); end
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_out); end
    reset    = 1'b0;
    ready_in = 1'b1;
  endtask

  task automatic test_even_weight();
    int cycles;
    runVector(packVec(48, 16, 40, 8), 32'hA5, cycles);
    checks++;
    if (cycles !== 5) begin errors++; $display("[TB] FAIL even_latency: got %0d expected 5", cycles); end
    checks++;
    if (selection_out !== 4'b0001) begin errors++; $display("[TB] FAIL even_sel: got %b expected 0001", selection_out); end
    checks++;
    if (data_out !== packVec(-16, -16, 8, -24)) begin errors++; $display("[TB] FAIL even_data: got %h expected %h", data_out, packVec(-16, -16, 8, -24)); end
    checks++;
    if (tag_out !== 32'hA5) begin errors++; $display("[TB] FAIL even_tag: got %h expected a5", tag_out); end
  endtask

  task automatic test_odd_weight();
    int cycles;
    runVector(packVec(40, 24, 8, 8), 32'h5A, cycles);
    checks++;
    if (cycles !== 5) begin errors++; $display("[TB] FAIL odd_latency: got %0d expected 5", cycles); end
    checks++;
    if (selection_out !== 4'b0001) begin errors++; $display("[TB] FAIL odd_sel: got %b expected 0001", selection_out); end
    checks++;
    if (data_out !== packVec(-8, -8, -24, -24)) begin errors++; $display("[TB] FAIL odd_data: got %h expected %h", data_out, packVec(-8, -8, -24, -24)); end
    checks++;
    if (tag_out !== 32'h5A) begin errors++; $display("[TB] FAIL odd_tag: got %h expected 5a", tag_out); end
  endtask

  task automatic test_tie_break();
    int cycles;
    runVector(packVec(40, 24, 40, 0), 32'h1234, cycles);
    checks++;
    if (cycles !== 5) begin errors++; $display("[TB] FAIL tie_latency: got %0d expected 5", cycles); end
    checks++;
    if (selection_out !== 4'b0100) begin errors++; $display("[TB] FAIL tie_sel: got %b expected 0100", selection_out); end
    checks++;
    if (data_out !== packVec(8, -8, -8, -32)) begin errors++; $display("[TB] FAIL tie_data: got %h expected %h", data_out, packVec(8, -8, -8, -32)); end
  endtask

  task automatic test_saturation();
    int cycles;
    runVector(packVec(-128, -128, -128, -128), 32'hDEAD, cycles);
    checks++;
    if (cycles !== 5) begin errors++; $display("[TB] FAIL sat_latency: got %0d expected 5", cycles); end
    checks++;
    if (selection_out !== 4'b0001) begin errors++; $display("[TB] FAIL sat_sel: got %b expected 0001", selection_out); end
    checks++;
    if (data_out !== packVec(95, -128, -128, -128)) begin errors++; $display("[TB] FAIL sat_data: got %h expected %h", data_out, packVec(95, -128, -128, -128)); end
  endtask

  task automatic test_backpressure();
    logic [31:0] expTag [3];
    logic [31:0] expData [3];
    logic [3:0]  expSel [3];
    logic [31:0] vecs [3];
    int cycles;
    int got;
    vecs[0] = packVec(48, 16, 40, 8);  expTag[0] = 32'h11; expData[0] = packVec(-16, -16, 8, -24); expSel[0] = 4'b0001;
    vecs[1] = packVec(40, 24, 8, 8);   expTag[1] = 32'h22; expData[1] = packVec(-8, -8, -24, -24);  expSel[1] = 4'b0001;
    vecs[2] = packVec(40, 24, 40, 0);  expTag[2] = 32'h33; expData[2] = packVec(8, -8, -8, -32);    expSel[2] = 4'b0100;
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = vecs[k];
      tag_in   = expTag[k];
    end
    @(negedge clk);
    valid_in = 1'b0;
    cycles = 0;
    while (valid_out !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_out: got %b expected 1", valid_out); end
    ready_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid: got %b expected 1", valid_out); end
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready: got %b expected 0", ready_out); end
    checks++;
    if (tag_out !== expTag[0]) begin errors++; $display("[TB] FAIL bp_hold_tag: got %h expected %h", tag_out, expTag[0]); end
    checks++;
    if (data_out !== expData[0]) begin errors++; $display("[TB] FAIL bp_hold_data: got %h expected %h", data_out, expData[0]); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy: got %b expected 1", busy); end
    ready_in = 1'b1;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      if (valid_out === 1'b1) begin
        if (got < 3) begin
          checks++;
          if (tag_out !== expTag[got]) begin errors++; $display("[TB] FAIL bp_tag%0d: got %h expected %h", got, tag_out, expTag[got]); end
          checks++;
          if (data_out !== expData[got]) begin errors++; $display("[TB] FAIL bp_data%0d: got %h expected %h", got, data_out, expData[got]); end
          checks++;
          if (selection_out !== expSel[got]) begin errors++; $display("[TB] FAIL bp_sel%0d: got %b expected %b", got, selection_out, expSel[got]); end
        end
        got++;
      end
      @(negedge clk);
    end
    checks++;
    if (got !== 3) begin errors++; $display("[TB] FAIL bp_count: got %0d outputs expected 3", got); end
  endtask

  task automatic test_reset_midstream();
    int cycles;
    ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b1; data_in = packVec(40, 24, 8, 8); tag_in = 32'h77;
    @(negedge clk);
    valid_in = 1'b1; data_in = packVec(-128, 0, 127, 5); tag_in = 32'h88;
    @(negedge clk);
    valid_in = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", valid_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    checks++;
    if (data_out !== '0) begin errors++; $display("[TB] FAIL mid_data: got %h expected 0", data_out); end
    reset = 1'b0;
    runVector(packVec(48, 16, 40, 8), 32'hA5, cycles);
    checks++;
    if (cycles !== 5) begin errors++; $display("[TB] FAIL mid_latency: got %0d expected 5", cycles); end
    checks++;
    if (selection_out !== 4'b0001) begin errors++; $display("[TB] FAIL mid_sel: got %b expected 0001", selection_out); end
    checks++;
    if (data_out !== packVec(-16, -16, 8, -24)) begin errors++; $display("[TB] FAIL mid_out_data: got %h expected %h", data_out, packVec(-16, -16, 8, -24)); end
    checks++;
    if (tag_out !== 32'hA5) begin errors++; $display("[TB] FAIL mid_tag: got %h expected a5", tag_out); end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_dup: got %b expected 0", valid_out); end
  endtask

  initial begin
    test_reset();
    test_even_weight();
    test_odd_weight();
    test_tie_break();
    test_saturation();
    test_backpressure();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
